// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard interface: decoded control fields in, issue decision
// and write-back schedule out.
interface issue_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_writereg;
  logic        id_selimregb;
  logic        id_readmem;
  logic        id_writemem;
  logic        id_mul;

  logic        issue;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_unit;
  logic        busy;
  logic [15:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_writereg, id_selimregb,
           id_readmem, id_writemem, id_mul,
    input  issue, stall, wb_valid, wb_rd, wb_unit, busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_writereg, id_selimregb,
           id_readmem, id_writemem, id_mul,
    output issue, stall, wb_valid, wb_rd, wb_unit, busy, stall_count
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: stalls decode on RAW/WAW hazards and on
// write-back port collisions between fixed-latency units.
module issue_scoreboard #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic            clock,
  input  logic            reset,
  issue_scoreboard_if.slave sb
);

  localparam logic [1:0] UNIT_ALU = 2'b00;
  localparam logic [1:0] UNIT_MEM = 2'b01;
  localparam logic [1:0] UNIT_MUL = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] unit;
  } slot_t;

  slot_t       slot_q     [8];
  slot_t       slot_d     [8];
  slot_t       slot_shift [8];
  logic [31:0] pending_q, pending_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic [3:0]  lat;
  logic [1:0]  unit;
  logic        producer;
  logic [8:0]  slot_busy;
  logic [31:0] wb_mask;
  logic [31:0] pending_eff;
  logic        raw, waw, port;
  logic        issue, stall;

  always_comb begin
    lat  = 4'(ALU_LAT);
    unit = UNIT_ALU;
    if (sb.id_readmem) begin
      lat  = 4'(MEM_LAT);
      unit = UNIT_MEM;
    end else if (sb.id_mul) begin
      lat  = 4'(MUL_LAT);
      unit = UNIT_MUL;
    end
  end

  assign producer = sb.id_writereg & (sb.id_rd != 5'd0) & ~sb.id_writemem;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      assign slot_busy[gi] = slot_q[gi].valid;
      if (gi < 7) begin : g_shift
        assign slot_shift[gi] = slot_q[gi+1];
      end else begin : g_tail
        assign slot_shift[gi] = '0;
      end
    end
  endgenerate
  // Slot 8 does not exist; a latency of 8 can never collide.
  assign slot_busy[8] = 1'b0;

  // The register being written back this cycle is already readable downstream.
  assign wb_mask     = slot_q[0].valid ? (32'd1 << slot_q[0].rd) : 32'd0;
  assign pending_eff = pending_q & ~wb_mask;

  assign raw   = pending_eff[sb.id_rs1] | (~sb.id_selimregb & pending_eff[sb.id_rs2]);
  assign waw   = producer & pending_eff[sb.id_rd];
  assign port  = producer & slot_busy[lat];
  assign issue = sb.id_valid & ~reset & ~(raw | waw | port);
  assign stall = sb.id_valid & ~issue;

  always_comb begin
    slot_d        = slot_shift;
    pending_d     = pending_q;
    stall_count_d = stall_count_q;
    if (slot_q[0].valid) pending_d[slot_q[0].rd] = 1'b0;
    // Set after clear so a same-edge reissue of the retiring register wins.
    if (issue & producer) begin
      slot_d[3'(lat - 4'd1)] = {1'b1, sb.id_rd, unit};
      pending_d[sb.id_rd]    = 1'b1;
    end
    pending_d[0] = 1'b0;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) slot_q[k] <= '0;
      pending_q     <= '0;
      stall_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      pending_q     <= pending_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign sb.issue       = issue;
  assign sb.stall       = stall;
  assign sb.wb_valid    = slot_q[0].valid;
  assign sb.wb_rd       = slot_q[0].rd;
  assign sb.wb_unit     = slot_q[0].unit;
  assign sb.busy        = |slot_busy[7:0];
  assign sb.stall_count = stall_count_q;

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue scoreboard for the i2o2 RISC-V "mini" pipeline. It sits between decode and the execute units (ALU, memory, multiplier) and uses the decoded control signals to decide each cycle whether the instruction in decode may issue. Issue stalls on RAW and WAW register hazards and on write-back port conflicts between units of different fixed latency. The block schedules the single register-file write-back port, so completion may be out of order.

## Interface
Parameters:
- ALU_LAT, 1, cycles from issue to write-back for ALU ops (ADD, ADDI)
- MEM_LAT, 3, cycles from issue to write-back for loads (LW)
- MUL_LAT, 4, cycles from issue to write-back for MULT
- Constraint: 1 ≤ ALU_LAT ≤ MEM_LAT ≤ MUL_LAT ≤ 8

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_writereg  in  1  instruction writes the register file (Control writereg)
- id_selimregb  in  1  1 = second operand is an immediate, so rs2 is unused
- id_readmem  in  1  load
- id_writemem  in  1  store
- id_mul  in  1  MULT
- issue  out  1  combinational; instruction issues this cycle
- stall  out  1  combinational; id_valid & ~issue
- wb_valid  out  1  registered; a scheduled write-back occurs this cycle
- wb_rd  out  5  registered; destination of that write-back
- wb_unit  out  2  registered; 00 = ALU, 01 = MEM, 10 = MUL
- busy  out  1  at least one write-back is outstanding
- stall_count  out  16  saturating count of stall cycles

## Operation
- **Latency selection:**
  - L = MEM_LAT if id_readmem
  - else L = MUL_LAT if id_mul
  - else L = ALU_LAT
- **Producer:** id_writereg=1, id_rd≠0, and id_writemem=0.
  - Non-producers (stores, rd=x0) issue without reserving anything.
- **Pending vector:** pending[1..31].
  - Set at the edge of issue of a producer.
  - Cleared at the edge ending its write-back cycle.
  - Same-edge set and clear of the same register: set wins.
  - pending[0] is always 0.
- **Write-back schedule:** slots s[0..7], each holding {valid, rd, unit}.
  - Every edge: s[k] ← s[k+1], and s[7] is emptied.
  - A producer issued in cycle t with latency L is written into s[L-1] on that edge.
  - wb_* outputs are driven from s[0].
- **Hazard check (combinational).** issue = id_valid & ~(RAW | WAW | PORT).
  - **RAW:** pending_eff[rs1], or (~id_selimregb & pending_eff[rs2]).
  - **WAW:** producer & pending_eff[rd].
  - **PORT:** producer & s[L].valid. This means a write-back is already scheduled for cycle t+L.
- **Forwarding:** pending_eff[r] = pending[r] & ~(wb_valid & wb_rd==r).
  - A consumer may issue in the same cycle as its producer's write-back.
- **busy:** OR of all slot valid bits.
- **stall_count:** increments each cycle stall=1; holds at 16'hFFFF.
- **Reset:**
  - Clears pending, all slots and stall_count.
  - wb_valid=0, wb_rd=0, wb_unit=0, busy=0.
  - Instructions in flight at reset never write back.
  - issue is forced to 0 during the reset cycle.

## Timing
- Producer issued in cycle t: wb_valid=1 with wb_rd=rd in exactly cycle t+L, for one cycle.
- Dependent instruction: issues no earlier than cycle t+L.
- issue/stall depend combinationally on the id_* inputs and on the current state only. There is no internal path from issue back into issue.
- Decode must hold id_* stable while stall=1.
- At most one write-back per cycle, guaranteed by the PORT check.
- Units of different latency may complete out of program order, e.g. a later ALU op before an earlier MUL.

## Test plan
- **ALU write-back:** reset; ADD x3,x1,x2 at t0 → issue=1 at t0; wb_valid=1, wb_rd=3, wb_unit=00 at t1; busy=0 at t2.
- **RAW on load:** LW x5 at t0; ADD x6,x5,x1 presented from t1 → stall at t1 and t2; issue at t3, same cycle as the x5 write-back; stall_count=2.
- **Port conflict:** MULT x7 at t0 (wb t4); LW x9 at t1 would also write back at t4 → stall at t1, issue at t2; write-backs x7 at t4 and x9 at t5.
- **WAW and out-of-order completion:**
  - LW x4 at t0, then ADD x4 → issues at t3.
  - Separately, MULT x7 at t0 then ADD x8 at t1 → x8 writes back at t2, before x7 at t4.
- **x0 and stores:**
  - ADD x0 never reserves a slot or sets pending.
  - A consumer of x0 never stalls.
  - SW with pending rs2 stalls; SW with id_selimregb=1 ignores rs2.
- **Reset mid-flight:** MULT x7 at t0, reset high at t2 → wb_valid stays 0 through t6; busy=0 and stall_count=0 from t3.
